// File: rtl/cacheline_adaptor.sv
// Cache-line <-> 4-beat 64-bit burst adaptor between the cache controller and physical memory.
// Optional idle-beat watchdog compiled in with `define CACHELINE_ADAPTOR_TIMEOUT_EN.
module cacheline_adaptor #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [255:0] line_i,
   output logic [255:0] line_o,
   input  logic [31:0]  address_i,
   input  logic         read_i,
   input  logic         write_i,
   output logic         resp_o,
   output logic         err_o,
   input  logic [63:0]  burst_i,
   output logic [63:0]  burst_o,
   output logic [31:0]  address_o,
   output logic         read_o,
   output logic         write_o,
   input  logic         resp_i
);

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
   typedef enum logic [2:0] {StIdle, StRd, StWr, StDone, StErr} state_t;
   localparam int unsigned WdogW = $clog2(TIMEOUT_CYCLES + 1);
`else
   typedef enum logic [2:0] {StIdle, StRd, StWr, StDone} state_t;
`endif

   state_t         r_state, w_state_nxt;
   logic [1:0]     r_cnt, w_cnt_nxt;
   logic [255:0]   r_buf, w_buf_nxt;
   logic [255:0]   r_line, w_line_nxt;
   logic [31:0]    r_addr, w_addr_nxt;
   logic           r_read, w_read_nxt;
   logic           r_write, w_write_nxt;
   logic           r_resp, w_resp_nxt;
   logic           w_unused;

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
   logic             r_err, w_err_nxt;
   logic [WdogW-1:0] r_wdog, w_wdog_nxt;
   assign w_unused = ^address_i[4:0];
`else
   assign w_unused = ^address_i[4:0] ^ (TIMEOUT_CYCLES == 0);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= StIdle;
         r_cnt   <= 2'd0;
         r_buf   <= '0;
         r_line  <= '0;
         r_addr  <= '0;
         r_read  <= 1'b0;
         r_write <= 1'b0;
         r_resp  <= 1'b0;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
         r_err   <= 1'b0;
         r_wdog  <= '0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_buf   <= w_buf_nxt;
         r_line  <= w_line_nxt;
         r_addr  <= w_addr_nxt;
         r_read  <= w_read_nxt;
         r_write <= w_write_nxt;
         r_resp  <= w_resp_nxt;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
         r_err   <= w_err_nxt;
         r_wdog  <= w_wdog_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_buf_nxt   = r_buf;
      w_line_nxt  = r_line;
      w_addr_nxt  = r_addr;
      w_read_nxt  = r_read;
      w_write_nxt = r_write;
      w_resp_nxt  = 1'b0;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
      w_err_nxt   = 1'b0;
      w_wdog_nxt  = r_wdog;
`endif
      unique case (r_state)
         StIdle: begin
            // Write wins when both requests are raised together.
            if (write_i) begin
               w_buf_nxt   = line_i;
               w_addr_nxt  = {address_i[31:5], 5'b0};
               w_write_nxt = 1'b1;
               w_cnt_nxt   = 2'd0;
               w_state_nxt = StWr;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
               w_wdog_nxt  = '0;
`endif
            end else if (read_i) begin
               w_addr_nxt  = {address_i[31:5], 5'b0};
               w_read_nxt  = 1'b1;
               w_cnt_nxt   = 2'd0;
               w_state_nxt = StRd;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
               w_wdog_nxt  = '0;
`endif
            end
         end
         StRd, StWr: begin
            if (resp_i) begin
               if (r_state == StRd) begin
                  w_buf_nxt[64*r_cnt +: 64] = burst_i;
               end
               w_cnt_nxt = r_cnt + 2'd1;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
               w_wdog_nxt = '0;
`endif
               if (r_cnt == 2'd3) begin
                  w_read_nxt  = 1'b0;
                  w_write_nxt = 1'b0;
                  w_resp_nxt  = 1'b1;
                  w_state_nxt = StDone;
                  // Fill line becomes visible only once complete.
                  if (r_state == StRd) begin
                     w_line_nxt = w_buf_nxt;
                  end
               end
            end
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
            else if (r_wdog == WdogW'(TIMEOUT_CYCLES - 1)) begin
               w_read_nxt  = 1'b0;
               w_write_nxt = 1'b0;
               w_err_nxt   = 1'b1;
               w_cnt_nxt   = 2'd0;
               w_state_nxt = StErr;
            end else begin
               w_wdog_nxt = r_wdog + WdogW'(1);
            end
`endif
         end
         StDone: w_state_nxt = StIdle;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
         StErr:  w_state_nxt = StIdle;
`endif
         default: w_state_nxt = StIdle;
      endcase
   end

   assign line_o    = r_line;
   assign address_o = r_addr;
   assign read_o    = r_read;
   assign write_o   = r_write;
   assign resp_o    = r_resp;
   assign burst_o   = r_write ? r_buf[64*r_cnt +: 64] : 64'd0;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
   assign err_o     = r_err;
`else
   assign err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: directed and random bursts against a line-level model.
module tb_cacheline_adaptor;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [255:0] line_i = '0;
   logic [255:0] line_o;
   logic [31:0]  address_i = '0;
   logic         read_i = 1'b0;
   logic         write_i = 1'b0;
   logic         resp_o;
   logic         err_o;
   logic [63:0]  burst_i = '0;
   logic [63:0]  burst_o;
   logic [31:0]  address_o;
   logic         read_o;
   logic         write_o;
   logic         resp_i = 1'b0;

   int errors = 0;
   int checks = 0;
   logic [255:0] last_fill = '0;

   cacheline_adaptor #(.TIMEOUT_CYCLES(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .line_i    (line_i),
      .line_o    (line_o),
      .address_i (address_i),
      .read_i    (read_i),
      .write_i   (write_i),
      .resp_o    (resp_o),
      .err_o     (err_o),
      .burst_i   (burst_i),
      .burst_o   (burst_o),
      .address_o (address_o),
      .read_o    (read_o),
      .write_o   (write_o),
      .resp_i    (resp_i)
   );

   always #5 clk = ~clk;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk256(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] rand_line();
      logic [255:0] l;
      for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom();
      return l;
   endfunction

   // mode: 0 beat every cycle, 1 every other cycle, 2 random (max 3 idle in a row),
   // 3 stall 20 cycles then beat every cycle.
   task automatic run_txn(input bit is_wr, input bit both, input logic [31:0] addr,
                          input logic [255:0] data, input int mode, input int exp_cyc);
      int beat;
      int cyc;
      int idle_run;
      logic [31:0] exp_addr;
      exp_addr = {addr[31:5], 5'b0};
      @(negedge clk);
      write_i   = is_wr;
      read_i    = !is_wr || both;
      address_i = addr;
      line_i    = is_wr ? data : rand_line();
      @(negedge clk);
      // Change inputs after accept: the adaptor must use its latched copies.
      address_i = $urandom();
      line_i    = ~data;
      beat      = 0;
      cyc       = 0;
      idle_run  = 0;
      while (beat < 4 && cyc < 64) begin
         chk1("read_o_busy", read_o, !is_wr);
         chk1("write_o_busy", write_o, is_wr);
         chk32("address_o", address_o, exp_addr);
         chk1("resp_o_busy", resp_o, 1'b0);
         chk1("err_o_busy", err_o, 1'b0);
         if (is_wr) chk64("burst_o", burst_o, data[64*beat +: 64]);
         case (mode)
            0: resp_i = 1'b1;
            1: resp_i = (cyc % 2) == 1;
            2: resp_i = (idle_run >= 3) ? 1'b1 : 1'(($urandom() % 2));
            default: resp_i = (cyc >= 20);
         endcase
         idle_run = resp_i ? 0 : idle_run + 1;
         burst_i = is_wr ? 64'($urandom()) : data[64*beat +: 64];
         @(negedge clk);
         if (resp_i) beat++;
         cyc++;
      end
      chk32("beats_taken", beat, 32'd4);
      if (exp_cyc > 0) chk32("req_cycles", cyc, exp_cyc);
      resp_i = (mode == 2) ? 1'($urandom() % 2) : 1'b0;
      if (!is_wr) last_fill = data;
      chk1("resp_o_done", resp_o, 1'b1);
      chk1("read_o_done", read_o, 1'b0);
      chk1("write_o_done", write_o, 1'b0);
      chk256("line_o", line_o, last_fill);
      read_i  = 1'b0;
      write_i = 1'b0;
      @(negedge clk);
      resp_i = 1'b0;
      chk1("resp_o_pulse", resp_o, 1'b0);
      chk1("read_o_after", read_o, 1'b0);
      chk1("write_o_after", write_o, 1'b0);
   endtask

   initial begin
      logic [255:0] l;
      int cyc;

      // Reset state.
      repeat (2) @(negedge clk);
      chk256("rst_line_o", line_o, '0);
      chk1("rst_read_o", read_o, 1'b0);
      chk1("rst_write_o", write_o, 1'b0);
      chk1("rst_resp_o", resp_o, 1'b0);
      chk1("rst_err_o", err_o, 1'b0);
      chk32("rst_address_o", address_o, 32'd0);
      chk64("rst_burst_o", burst_o, 64'd0);
      rst = 1'b0;

      // Directed read, back-to-back beats.
      l = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
      run_txn(1'b0, 1'b0, 32'h0000_1234, l, 0, 4);

      // Directed write, beat every other cycle; line_o must keep the last fill.
      l = {64'hFEDC_BA98_7654_3210, 64'h0F1E_2D3C_4B5A_6978,
           64'hDEAD_BEEF_CAFE_F00D, 64'h0123_4567_89AB_CDEF};
      run_txn(1'b1, 1'b0, 32'h0000_2000, l, 1, 8);

      // Simultaneous read and write: write wins, then the read on its own.
      run_txn(1'b1, 1'b1, 32'h0000_0040, rand_line(), 0, 4);
      run_txn(1'b0, 1'b0, 32'h0000_0040, rand_line(), 2, 0);

      // resp_i in IDLE is ignored.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         resp_i = 1'b1;
         chk1("idle_read_o", read_o, 1'b0);
         chk1("idle_write_o", write_o, 1'b0);
         chk1("idle_resp_o", resp_o, 1'b0);
      end
      resp_i = 1'b0;

      // Asynchronous reset after two read beats.
      @(negedge clk);
      read_i    = 1'b1;
      address_i = 32'h0000_0200;
      @(negedge clk);
      resp_i  = 1'b1;
      burst_i = 64'hAAAA_AAAA_AAAA_AAAA;
      @(negedge clk);
      burst_i = 64'h5555_5555_5555_5555;
      @(negedge clk);
      resp_i = 1'b0;
      chk1("mid_read_o", read_o, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk1("arst_read_o", read_o, 1'b0);
      chk1("arst_resp_o", resp_o, 1'b0);
      chk256("arst_line_o", line_o, '0);
      chk32("arst_address_o", address_o, 32'd0);
      read_i    = 1'b0;
      last_fill = '0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk1("post_rst_resp_o", resp_o, 1'b0);
      run_txn(1'b0, 1'b0, 32'h0000_0100, rand_line(), 0, 4);

      // Random mix of reads and writes with random beat spacing.
      for (int i = 0; i < 12; i++) begin
         run_txn(1'($urandom() % 2), 1'b0, $urandom(), rand_line(), 2, 0);
      end

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
      // Watchdog: no beats after accept.
      @(negedge clk);
      read_i    = 1'b1;
      address_i = 32'h0000_3000;
      @(negedge clk);
      cyc = 0;
      while (read_o === 1'b1 && cyc < 50) begin
         chk1("wd_resp_o", resp_o, 1'b0);
         chk1("wd_err_o_early", err_o, 1'b0);
         @(negedge clk);
         cyc++;
      end
      chk32("wd_stall_cycles", cyc, 32'd8);
      chk1("wd_err_o", err_o, 1'b1);
      chk1("wd_resp_o_err", resp_o, 1'b0);
      chk256("wd_line_o", line_o, last_fill);
      read_i = 1'b0;
      @(negedge clk);
      chk1("wd_err_pulse", err_o, 1'b0);
      chk1("wd_read_o_idle", read_o, 1'b0);
      @(negedge clk);
      chk1("wd_read_o_idle2", read_o, 1'b0);
      run_txn(1'b0, 1'b0, 32'h0000_3000, rand_line(), 0, 4);
`else
      // Without the watchdog a long stall simply waits.
      run_txn(1'b0, 1'b0, 32'h0000_3000, rand_line(), 3, 24);
      run_txn(1'b1, 1'b0, 32'h0000_3020, rand_line(), 3, 24);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
- Memory-side counterpart of the icache/dcache line storage.
- Turns one 256-bit cache-line request into a 4-beat, 64-bit burst transaction on the physical memory port.
  - Read fill: collects 4 beats into a line for the data array.
  - Writeback: splits a 256-bit dirty line into 4 beats.
- Sits between the cache controller and the arbiter/physical memory.

Parameters:
- TIMEOUT_CYCLES, 255: idle-beat watchdog limit, in cycles. Used only when the optional feature is compiled in.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- line_i  in  256  line to write back; sampled at write accept
- line_o  out  256  assembled fill line; valid while resp_o=1
- address_i  in  32  line address from cache; sampled at accept
- read_i  in  1  cache fill request; level, held until resp_o
- write_i  in  1  cache writeback request; level, held until resp_o
- resp_o  out  1  one-cycle completion pulse
- err_o  out  1  one-cycle abort pulse; optional feature only
- burst_i  in  64  memory read beat
- burst_o  out  64  memory write beat
- address_o  out  32  burst address = {address_i[31:5], 5'b0}
- read_o  out  1  memory burst read request
- write_o  out  1  memory burst write request
- resp_i  in  1  memory beat strobe; one beat per high cycle

Behaviour:
- Reset, applied asynchronously:
  - State goes to IDLE; beat counter is 0; line buffer is cleared.
  - All outputs are 0.
  - Reset mid-burst abandons the transaction and produces no resp_o.
- FSM states: IDLE, RD, WR, DONE (plus ERR with the optional feature).
- IDLE:
  - If write_i=1: latch line_i and the aligned address; go to WR. Write has priority when read_i and write_i are both high.
  - Else if read_i=1: latch the aligned address; go to RD.
  - Otherwise stay in IDLE.
- Outputs are registered. read_o/write_o rise in the cycle after accept, so accept at edge N gives request high from N+1.
- RD:
  - read_o=1 and address_o is held.
  - On each cycle with resp_i=1, burst_i is stored into line[64*cnt +: 64] and cnt increments. Beat 0 is bytes 0-7 (little-endian beat order).
  - On the beat where cnt=3: read_o is cleared at the same edge, cnt wraps to 0, and the FSM goes to DONE.
  - resp_i=0 cycles stall with no state change.
- WR:
  - write_o=1 and burst_o = line[64*cnt +: 64].
  - Advance and terminate exactly as in RD.
  - burst_o shows the next beat in the cycle after each accepted beat.
- DONE:
  - resp_o=1 for exactly one cycle. For reads, line_o holds the full line.
  - Next state is IDLE. read_i/write_i are ignored in DONE, because the cache drops them on seeing resp_o.
- line_o holds the last filled line until the next fill overwrites it. It is 0 after reset.
- resp_i while in IDLE or DONE is ignored.
- Minimum latency with resp_i tied high: accept at edge 0, beats at edges 1-4, resp_o high in cycle 5. That is 6 cycles from the request to the first possible new accept.
- Requests arriving outside IDLE are not queued.

Optional Feature:
- Macro: CACHELINE_ADAPTOR_TIMEOUT_EN.
- Defined:
  - A watchdog counter resets on every resp_i beat and on entry to RD/WR, and increments on every stalled cycle in RD/WR.
  - On reaching TIMEOUT_CYCLES: clear read_o/write_o, go to ERR, pulse err_o for one cycle (resp_o stays 0), then return to IDLE.
  - line_o keeps its previous value; no partial beats are exposed.
- Undefined: err_o is tied 0, no watchdog logic exists, and stalls are unbounded.

Test Plan:
- Reset during RD after 2 beats -> read_o=0 and resp_o=0 immediately. After release, a new read of 0x100 completes normally.
- Read of 0x0000_1234 with resp_i high every cycle and beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> address_o=0x0000_1220, read_o high for 4 cycles, resp_o high in cycle 5, line_o = {44..44,33..33,22..22,11..11}.
- Write of line 0x0123...CDEF (distinct 64-bit quarters) with resp_i high every other cycle -> write_o high for 8 cycles, burst_o shows quarters 0..3 in order, single resp_o pulse.
- read_i=write_i=1 together at 0x40 -> write burst executes, read_o stays 0. After resp_o and reassertion of only read_i, the read proceeds.
- Macro defined, TIMEOUT_CYCLES=8, resp_i never asserted after read accept -> read_o drops after 8 stalled cycles, err_o pulses once, resp_o never asserts, FSM back in IDLE.
